// File: rtl/seq_arith_if.sv
// seq_arith_if: operand/result handshake bundle for seq_arith_unit
interface seq_arith_if #(
  parameter int WIDTH = 8
) ();
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0] op;
  logic sat;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] Out;
  logic overflow;
  modport master (
    output in_valid, A, B, op, sat, out_ready,
    input in_ready, out_valid, Out, overflow
  );
  modport slave (
    input in_valid, A, B, op, sat, out_ready,
    output in_ready, out_valid, Out, overflow
  );
endinterface

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked signed add/sub and iterative shift-add mul with optional saturation
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  seq_arith_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = ~MIN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic [1:0] state;
  logic [2*WIDTH-1:0] acc, a_sh, acc_nx;
  logic [WIDTH-1:0] b_sh, a_mag, b_mag, out_r, as_res, mul_res, prod_lo;
  logic [WIDTH:0] sum;
  logic [CNT_W-1:0] cnt;
  logic neg, sat_r, ovf_r, sum_ovf, mul_ovf, accept;
  always_comb begin
    accept = bus.in_valid && state == IDLE;
    sum = bus.op[0] ? {bus.A[WIDTH-1], bus.A} - {bus.B[WIDTH-1], bus.B}
                    : {bus.A[WIDTH-1], bus.A} + {bus.B[WIDTH-1], bus.B};
    sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];
    as_res = bus.op[1] ? '0 : sum_ovf && bus.sat ? (sum[WIDTH] ? MIN : MAX) : sum[WIDTH-1:0];
    a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
    acc_nx = acc + (b_sh[0] ? a_sh : '0);
    prod_lo = neg ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    mul_ovf = acc_nx > (neg ? {{WIDTH{1'b0}}, MIN} : {{WIDTH{1'b0}}, MAX});
    mul_res = mul_ovf && sat_r ? (neg ? MIN : MAX) : prod_lo;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      cnt <= '0;
      neg <= 1'b0;
      sat_r <= 1'b0;
      out_r <= '0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      state <= bus.op == 2'b10 ? MUL : DONE;
      out_r <= as_res;
      ovf_r <= !bus.op[1] && sum_ovf;
      acc <= '0;
      a_sh <= {{WIDTH{1'b0}}, a_mag};
      b_sh <= b_mag;
      cnt <= '0;
      neg <= (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) && |bus.A && |bus.B;
      sat_r <= bus.sat;
    end else if (state == MUL) begin
      acc <= acc_nx;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      state <= cnt == LAST ? DONE : MUL;
      out_r <= cnt == LAST ? mul_res : out_r;
      ovf_r <= cnt == LAST ? mul_ovf : ovf_r;
    end else if (state == DONE && bus.out_ready) begin
      state <= IDLE;
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.Out = out_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed vectors, handshake corner cases and random ops against a behavioural model
module tb_seq_arith_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  seq_arith_if #(.WIDTH(8)) bus8 ();
  seq_arith_if #(.WIDTH(16)) bus16 ();
  seq_arith_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  seq_arith_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic sat;
    logic [7:0] out;
    logic ovf;
    int lat;
  } vec_t;
  vec_t vecs[16];
  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  function automatic void model(input int w, input longint a, input longint b, input logic [1:0] op,
                                input logic s, output longint o, output logic v);
    longint t, lo, hi;
    lo = -(longint'(1) <<< (w - 1));
    hi = -lo - 1;
    t = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a * b : 0;
    v = t < lo || t > hi;
    o = (v && s ? (t < 0 ? lo : hi) : t) & ((longint'(1) <<< w) - 1);
  endfunction
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op, input logic s,
                      input int hold, output logic [7:0] o, output logic v, output int lat);
    @(negedge clk);
    bus8.A = a;
    bus8.B = b;
    bus8.op = op;
    bus8.sat = s;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.A = 8'($urandom);
    bus8.B = 8'($urandom);
    bus8.op = 2'($urandom);
    bus8.sat = 1'($urandom);
    lat = 1;
    while (!bus8.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    o = bus8.Out;
    v = bus8.overflow;
    repeat (hold) @(negedge clk);
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
  endtask
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic s,
                       input int hold, output logic [15:0] o, output logic v, output int lat);
    @(negedge clk);
    bus16.A = a;
    bus16.B = b;
    bus16.op = op;
    bus16.sat = s;
    bus16.in_valid = 1'b1;
    bus16.out_ready = 1'b0;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.A = 16'($urandom);
    bus16.B = 16'($urandom);
    lat = 1;
    while (!bus16.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    o = bus16.Out;
    v = bus16.overflow;
    repeat (hold) @(negedge clk);
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask
  initial begin
    logic [7:0] o8;
    logic [15:0] o16;
    logic v;
    int lat;
    longint eo;
    logic ev;
    logic seen;
    logic [7:0] ra, rb;
    logic [15:0] wa, wb;
    logic [1:0] rop;
    logic rs;
    vecs[0] = '{8'd100, 8'd50, 2'd0, 1'b0, 8'h96, 1'b1, 1};
    vecs[1] = '{8'd100, 8'd50, 2'd0, 1'b1, 8'h7F, 1'b1, 1};
    vecs[2] = '{8'h80, 8'h01, 2'd1, 1'b0, 8'h7F, 1'b1, 1};
    vecs[3] = '{8'h80, 8'h01, 2'd1, 1'b1, 8'h80, 1'b1, 1};
    vecs[4] = '{8'h05, 8'h07, 2'd1, 1'b0, 8'hFE, 1'b0, 1};
    vecs[5] = '{8'hF0, 8'h08, 2'd2, 1'b0, 8'h80, 1'b0, 9};
    vecs[6] = '{8'h10, 8'h08, 2'd2, 1'b1, 8'h7F, 1'b1, 9};
    vecs[7] = '{8'h80, 8'hFF, 2'd2, 1'b1, 8'h7F, 1'b1, 9};
    vecs[8] = '{8'h80, 8'h01, 2'd2, 1'b0, 8'h80, 1'b0, 9};
    vecs[9] = '{8'h00, 8'hFB, 2'd2, 1'b0, 8'h00, 1'b0, 9};
    vecs[10] = '{8'h05, 8'h06, 2'd3, 1'b1, 8'h00, 1'b0, 1};
    vecs[11] = '{8'h10, 8'h08, 2'd2, 1'b0, 8'h80, 1'b1, 9};
    vecs[12] = '{8'h80, 8'h80, 2'd2, 1'b0, 8'h00, 1'b1, 9};
    vecs[13] = '{8'h80, 8'h80, 2'd2, 1'b1, 8'h7F, 1'b1, 9};
    vecs[14] = '{8'h07, 8'hFD, 2'd2, 1'b0, 8'hEB, 1'b0, 9};
    vecs[15] = '{8'h9C, 8'h9C, 2'd0, 1'b1, 8'h80, 1'b1, 1};
    {bus8.in_valid, bus8.out_ready, bus8.sat, bus8.op, bus8.A, bus8.B} = '0;
    {bus16.in_valid, bus16.out_ready, bus16.sat, bus16.op, bus16.A, bus16.B} = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", bus8.in_ready, 1);
    check("reset out_valid", bus8.out_valid, 0);
    check("reset Out", bus8.Out, 0);
    check("reset overflow", bus8.overflow, 0);
    check("reset16 in_ready", bus16.in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].sat, i % 3, o8, v, lat);
      check($sformatf("vec%0d Out", i), o8, vecs[i].out);
      check($sformatf("vec%0d overflow", i), v, vecs[i].ovf);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end
    @(negedge clk);
    bus8.A = 8'd3;
    bus8.B = 8'd4;
    bus8.op = 2'd0;
    bus8.sat = 1'b0;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.A = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d out_valid", i), bus8.out_valid, 1);
      check($sformatf("hold%0d Out", i), bus8.Out, 7);
      check($sformatf("hold%0d overflow", i), bus8.overflow, 0);
      check($sformatf("hold%0d in_ready", i), bus8.in_ready, 0);
      @(negedge clk);
    end
    bus8.A = 8'd9;
    bus8.B = 8'd9;
    bus8.op = 2'd2;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b0;
    check("xfer out_valid", bus8.out_valid, 0);
    check("xfer in_ready", bus8.in_ready, 1);
    @(negedge clk);
    check("no accept in_ready", bus8.in_ready, 1);
    bus8.A = 8'd5;
    bus8.B = 8'd5;
    bus8.op = 2'd2;
    bus8.in_valid = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midmul in_ready", bus8.in_ready, 1);
    check("midmul out_valid", bus8.out_valid, 0);
    check("midmul Out", bus8.Out, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.out_valid) seen = 1'b1;
    end
    check("midmul no result", seen, 0);
    run8(8'd3, 8'd3, 2'd2, 1'b0, 0, o8, v, lat);
    check("after reset 3*3 Out", o8, 9);
    check("after reset 3*3 overflow", v, 0);
    check("after reset 3*3 latency", lat, 9);
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rop = 2'($urandom);
      rs = 1'($urandom);
      model(8, longint'($signed(ra)), longint'($signed(rb)), rop, rs, eo, ev);
      run8(ra, rb, rop, rs, $urandom_range(0, 3), o8, v, lat);
      check($sformatf("rnd8 %0d Out", i), o8, eo);
      check($sformatf("rnd8 %0d overflow", i), v, ev);
      check($sformatf("rnd8 %0d latency", i), lat, rop == 2'd2 ? 9 : 1);
    end
    for (int i = 0; i < 100; i++) begin
      wa = 16'($urandom);
      wb = 16'($urandom);
      if (i % 4 == 0) wa = 16'h8000;
      if (i % 8 == 1) wb = 16'($signed(8'($urandom)));
      rop = 2'($urandom);
      rs = 1'($urandom);
      model(16, longint'($signed(wa)), longint'($signed(wb)), rop, rs, eo, ev);
      run16(wa, wb, rop, rs, $urandom_range(0, 3), o16, v, lat);
      check($sformatf("rnd16 %0d Out", i), o16, eo);
      check($sformatf("rnd16 %0d overflow", i), v, ev);
      check($sformatf("rnd16 %0d latency", i), lat, rop == 2'd2 ? 17 : 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
